ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_defs.sv | 14 +
 rtl/arb_hold_counter.sv | 37 +++
 rtl/ram_arbiter.sv | 104 ++++++++++
 tb/tb_ram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_defs.sv
// Shared definitions for the two-port RAM arbiter: state encodings and the
// default hold limit.
package ram_arb_defs;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10,
        TURN = 2'b11
    } arb_state_e;

    localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/arb_hold_counter.sv
// Counts cycles spent by the current owner; saturates at MAX_HOLD-1 and flags
// the terminal count so the arbiter can preempt a long burst.
module arb_hold_counter
    import ram_arb_defs::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for a 32-word RAM. The owner's access is
// muxed straight through; a one-cycle TURN gap separates ownership changes.
module ram_arbiter
    import ram_arb_defs::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [4:0] addr0,
    input  logic [4:0] addr1,
    input  logic       rden0,
    input  logic       rden1,
    input  logic       wren0,
    input  logic       wren1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [4:0] mem_address,
    output logic       mem_rden,
    output logic       mem_wren,
    output logic       busy
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;   // requester served most recently
    logic       own;
    logic       hold_tc;

    assign own = (state_q == OWN0) || (state_q == OWN1);

    // Held at zero outside ownership, so every entry into OWNx starts from 0.
    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk   (clk),
        .reset (reset),
        .clr_i (!own),
        .en_i  (own),
        .tc_o  (hold_tc)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE, TURN: begin
                if (req0 && req1)
                    state_d = last_q ? OWN0 : OWN1;
                else if (req0)
                    state_d = OWN0;
                else if (req1)
                    state_d = OWN1;
                else
                    state_d = IDLE;
            end
            OWN0: begin
                if (!req0 || (req1 && hold_tc)) begin
                    state_d = TURN;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (!req1 || (req0 && hold_tc)) begin
                    state_d = TURN;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);
    assign busy = (state_q != IDLE);

    // Gated on reset as well so a mid-burst reset cannot leak a write.
    always_comb begin
        mem_address = '0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        if (reset && (state_q == OWN0)) begin
            mem_address = addr0;
            mem_rden    = rden0;
            mem_wren    = wren0;
        end else if (reset && (state_q == OWN1)) begin
            mem_address = addr1;
            mem_rden    = rden1;
            mem_wren    = wren1;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, grant latency, hold limit, mux and
// mid-burst reset scenarios with hand-computed expectations.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [4:0] addr0, addr1;
    logic       rden0, rden1, wren0, wren1;
    logic       gnt0, gnt1;
    logic [4:0] mem_address;
    logic       mem_rden, mem_wren;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    ram_arbiter #(.MAX_HOLD(16)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .addr0       (addr0),
        .addr1       (addr1),
        .rden0       (rden0),
        .rden1       (rden1),
        .wren0       (wren0),
        .wren1       (wren1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .mem_address (mem_address),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // DUT updates on the falling edge; stimulus and sampling sit just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
        rden0 = 0; rden1 = 0; wren0 = 0; wren1 = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        clear_inputs();
        step();
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_grants: got %b expected 000", {gnt0, gnt1, busy});
        end
        n_tests++;
        if ({mem_address, mem_rden, mem_wren} !== 7'd0) begin
            n_fail++; $display("FAIL reset_mem: got %b expected 0", {mem_address, mem_rden, mem_wren});
        end
        req0 = 1; req1 = 1;
        step();
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_hold: got %b expected 000", {gnt0, gnt1, busy});
        end
        reset = 1;
        #1;
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_fail++; $display("FAIL pre_first_edge: got %b expected 000", {gnt0, gnt1, busy});
        end
        step();
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b101) begin
            n_fail++; $display("FAIL first_contention: got %b expected 101", {gnt0, gnt1, busy});
        end
        req0 = 0; req1 = 0;
        step();
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b001) begin
            n_fail++; $display("FAIL release_turn: got %b expected 001", {gnt0, gnt1, busy});
        end
        step();
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_fail++; $display("FAIL release_idle: got %b expected 000", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_no_preempt();
        req0 = 1; rden0 = 1; addr0 = 5'd3;
        wren1 = 1; addr1 = 5'd9;
        step();
        n_tests++;
        if ({mem_address, mem_rden, mem_wren} !== {5'd3, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL own0_mux: got %b expected %b", {mem_address, mem_rden, mem_wren}, {5'd3, 1'b1, 1'b0});
        end
        for (int i = 0; i < 40; i++) begin
            n_tests++;
            if ({gnt0, gnt1} !== 2'b10) begin
                n_fail++; $display("FAIL long_burst cycle %0d: got %b expected 10", i, {gnt0, gnt1});
            end
            if (i == 39) req0 = 0;
            step();
        end
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b001) begin
            n_fail++; $display("FAIL long_burst_turn: got %b expected 001", {gnt0, gnt1, busy});
        end
        step();
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_fail++; $display("FAIL long_burst_idle: got %b expected 000", {gnt0, gnt1, busy});
        end
        clear_inputs();
    endtask

    task automatic test_preempt();
        req0 = 1;
        step();
        for (int c = 1; c <= 16; c++) begin
            n_tests++;
            if ({gnt0, gnt1} !== 2'b10) begin
                n_fail++; $display("FAIL preempt_hold cycle %0d: got %b expected 10", c, {gnt0, gnt1});
            end
            if (c == 3) req1 = 1;
            step();
        end
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b001) begin
            n_fail++; $display("FAIL preempt_turn: got %b expected 001", {gnt0, gnt1, busy});
        end
        step();
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b011) begin
            n_fail++; $display("FAIL preempt_gnt1: got %b expected 011", {gnt0, gnt1, busy});
        end
        req0 = 0; req1 = 0;
        step();
        step();
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_fail++; $display("FAIL preempt_idle: got %b expected 000", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_mux();
        req1 = 1;
        step();
        wren0 = 1; addr0 = 5'd7; rden0 = 1;
        wren1 = 1; addr1 = 5'd20; rden1 = 0;
        #1;
        n_tests++;
        if ({mem_address, mem_rden, mem_wren} !== {5'd20, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL own1_mux: got %b expected %b", {mem_address, mem_rden, mem_wren}, {5'd20, 1'b0, 1'b1});
        end
        wren1 = 0;
        #1;
        n_tests++;
        if (mem_wren !== 1'b0) begin
            n_fail++; $display("FAIL non_owner_ignored: got %b expected 0", mem_wren);
        end
        req1 = 0;
        step();
        n_tests++;
        if ({busy, mem_address, mem_rden, mem_wren} !== {1'b1, 7'd0}) begin
            n_fail++; $display("FAIL turn_mux_zero: got %b expected %b", {busy, mem_address, mem_rden, mem_wren}, {1'b1, 7'd0});
        end
        step();
        n_tests++;
        if ({busy, mem_address, mem_rden, mem_wren} !== 8'd0) begin
            n_fail++; $display("FAIL idle_mux_zero: got %b expected 0", {busy, mem_address, mem_rden, mem_wren});
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        req1 = 1; wren1 = 1; addr1 = 5'd12;
        step();
        n_tests++;
        if ({gnt1, mem_wren, mem_address} !== {1'b1, 1'b1, 5'd12}) begin
            n_fail++; $display("FAIL burst_active: got %b expected %b", {gnt1, mem_wren, mem_address}, {1'b1, 1'b1, 5'd12});
        end
        reset = 0;
        #1;
        n_tests++;
        if ({gnt1, busy, mem_wren, mem_rden, mem_address} !== 9'd0) begin
            n_fail++; $display("FAIL async_reset: got %b expected 0", {gnt1, busy, mem_wren, mem_rden, mem_address});
        end
        clear_inputs();
        step();
        reset = 1;
        step();
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_fail++; $display("FAIL post_reset_idle: got %b expected 000", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_release_at_tc();
        req0 = 1;
        step();
        for (int c = 1; c <= 16; c++) begin
            n_tests++;
            if ({gnt0, gnt1} !== 2'b10) begin
                n_fail++; $display("FAIL tc_hold cycle %0d: got %b expected 10", c, {gnt0, gnt1});
            end
            if (c == 2) req1 = 1;
            if (c == 16) req0 = 0;
            step();
        end
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b001) begin
            n_fail++; $display("FAIL tc_release_turn: got %b expected 001", {gnt0, gnt1, busy});
        end
        // Re-contend in TURN: only last_served=0 yields a grant to requester 1.
        req0 = 1;
        step();
        n_tests++;
        if ({gnt0, gnt1} !== 2'b01) begin
            n_fail++; $display("FAIL tc_release_gnt1: got %b expected 01", {gnt0, gnt1});
        end
        req0 = 0; req1 = 0;
        step();
        step();
        n_tests++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_fail++; $display("FAIL tc_release_idle: got %b expected 000", {gnt0, gnt1, busy});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_no_preempt();
        test_preempt();
        test_mux();
        test_reset_mid_burst();
        test_release_at_tc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
